// File: rtl/mux_2to1_stream.sv
// rtl/mux_2to1_stream.sv - round-robin 2:1 valid/ready stream merge with registered output and source tag
module mux_2to1_stream #(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  B_valid,
  output logic                  B_ready,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic                  C_valid,
  output logic                  C_ready,
  output logic [DATA_WIDTH-1:0] A,
  output logic                  A_valid,
  input  logic                  A_ready,
  output logic                  Select
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic                  a_valid_q, a_valid_d;
  logic                  select_q, select_d;
  // last_q = 1 means the previous grant went to C, so B wins the next tie
  logic                  last_q, last_d;

  logic free;
  logic grant_b;
  logic grant_c;

  // Arbitration and next-state: grants depend only on valids, A_ready and the
  // tie-break bit, never on data, so the ready outputs stay data-independent.
  always_comb begin
    free      = !a_valid_q || A_ready;
    grant_b   = free && B_valid && (!C_valid || last_q);
    grant_c   = free && C_valid && (!B_valid || !last_q);
    a_d       = a_q;
    a_valid_d = a_valid_q;
    select_d  = select_q;
    last_d    = last_q;
    if (free) begin
      if (grant_b) begin
        a_d       = B;
        a_valid_d = 1'b1;
        select_d  = 1'b0;
        last_d    = 1'b0;
      end else if (grant_c) begin
        a_d       = C;
        a_valid_d = 1'b1;
        select_d  = 1'b1;
        last_d    = 1'b1;
      end else begin
        a_valid_d = 1'b0;
      end
    end
  end

  // Output register; async reset drops any pending beat and re-arms B priority
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      select_q  <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      select_q  <= select_d;
      last_q    <= last_d;
    end
  end

  // Readies are gated by reset so nothing looks accepted while the register is held clear
  always_comb begin
    B_ready = Rst_n && grant_b;
    C_ready = Rst_n && grant_c;
  end

  assign A       = a_q;
  assign A_valid = a_valid_q;
  assign Select  = select_q;

endmodule
